// File: rtl/regfile_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader_pkg
// Brief    : Shared widths and dump-sequencer state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_dump_reader_pkg;

    // Default geometry shared with the register file so both sides agree.
    localparam int ADD_WIDTH_DEFAULT  = 5;
    localparam int DATA_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader
// Brief    : Walks a register-file address range on a spare read port and
//            streams {addr, data} beats over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int addWidth  = ADD_WIDTH_DEFAULT,
    parameter int dataWidth = DATA_WIDTH_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [addWidth-1:0]  FIRST,
    input  logic [addWidth-1:0]  LAST,
    output logic [addWidth-1:0]  RF_ADDR,
    input  logic [dataWidth-1:0] RF_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [addWidth-1:0]  OUT_ADDR,
    output logic [dataWidth-1:0] OUT_DATA,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam logic [addWidth:0]   C_CNT_ONE = (addWidth+1)'(1);
    localparam logic [addWidth-1:0] C_IDX_ONE = addWidth'(1);

    state_e                 state_q,     state_d;
    logic [addWidth-1:0]    index_q,     index_d;
    logic [addWidth:0]      remaining_q, remaining_d;
    logic                   valid_q,     valid_d;
    logic [addWidth-1:0]    addr_q,      addr_d;
    logic [dataWidth-1:0]   data_q,      data_d;

    logic                   w_load;
    logic                   w_handshake;
    logic [addWidth-1:0]    w_span;

    assign w_load      = (state_q == ST_SCAN) && (!valid_q || OUT_READY);
    assign w_handshake = valid_q && OUT_READY;
    // Modular difference gives the wrapped range length minus one.
    assign w_span      = LAST - FIRST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            remaining_q <= remaining_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        remaining_d = remaining_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        data_d      = data_q;

        case (state_q)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    state_d     = ST_SCAN;
                    index_d     = FIRST;
                    remaining_d = {1'b0, w_span} + C_CNT_ONE;
                end
            end
            ST_SCAN: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if (w_load) begin
                    // A load in SCAN either fills an empty slot or replaces a beat being accepted.
                    addr_d      = index_q;
                    data_d      = RF_DATA;
                    valid_d     = 1'b1;
                    index_d     = index_q + C_IDX_ONE;
                    remaining_d = remaining_q - C_CNT_ONE;
                    if (remaining_q == C_CNT_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if (w_handshake) begin
                    state_d = ST_FIN;
                    valid_d = 1'b0;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign RF_ADDR   = index_q;
    assign OUT_VALID = valid_q;
    assign OUT_ADDR  = addr_q;
    assign OUT_DATA  = data_q;
    assign BUSY      = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign DONE      = (state_q == ST_FIN);

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_reader
// Brief    : Scoreboard bench for the register-file dump sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam logic [DW-1:0] C_POISON = 32'hDEADBEEF;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          ABORT = 1'b0;
    logic          OUT_READY = 1'b0;
    logic [AW-1:0] FIRST = '0;
    logic [AW-1:0] LAST = '0;
    logic [AW-1:0] RF_ADDR;
    logic [AW-1:0] OUT_ADDR;
    logic [DW-1:0] RF_DATA;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          BUSY;
    logic          DONE;

    // Register file stimulus (written only on clock edges) and independent expectation model.
    logic [DW-1:0] regs  [DEPTH];
    logic [DW-1:0] model [DEPTH];
    logic          preload = 1'b0;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    int            wr_c0 = -1, wr_c1 = -1;
    logic [AW-1:0] wr_a0 = '0, wr_a1 = '0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] held_beat;
    logic [AW+DW-1:0] exp_beat;
    bit               held   = 1'b0;
    bit               mon_en = 1'b1;
    int               n_checks = 0;
    int               n_fail   = 0;

    regfile_dump_reader #(.addWidth(AW), .dataWidth(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .ABORT     (ABORT),
        .FIRST     (FIRST),
        .LAST      (LAST),
        .RF_ADDR   (RF_ADDR),
        .RF_DATA   (RF_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_ADDR  (OUT_ADDR),
        .OUT_DATA  (OUT_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    assign RF_DATA = regs[RF_ADDR];

    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= DW'(i) * 32'h11111111;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Inputs change only just after posedge, so at negedge valid&ready predicts the next-edge handshake.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (held) begin
                n_checks++;
                if (OUT_VALID !== 1'b1 || {OUT_ADDR, OUT_DATA} !== held_beat) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h",
                             OUT_VALID, {OUT_ADDR, OUT_DATA}, held_beat);
                end
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h, required no beat", {OUT_ADDR, OUT_DATA});
                end else begin
                    exp_beat = exp_q.pop_front();
                    if ({OUT_ADDR, OUT_DATA} !== exp_beat) begin
                        n_fail++;
                        $display("FAIL beat: got addr=%0d data=%h, required addr=%0d data=%h",
                                 OUT_ADDR, OUT_DATA, exp_beat[AW+DW-1:DW], exp_beat[DW-1:0]);
                    end
                end
            end
            held      = (OUT_VALID === 1'b1) && (OUT_READY === 1'b0);
            held_beat = {OUT_ADDR, OUT_DATA};
        end else begin
            held = 1'b0;
        end
    end

    task automatic push_range(input logic [AW-1:0] first, input logic [AW-1:0] last);
        logic [AW-1:0] span;
        logic [AW-1:0] a;
        span = last - first;
        for (int k = 0; k <= int'(span); k++) begin
            a = first + AW'(k);
            exp_q.push_back({a, model[a]});
        end
    endtask

    task automatic start_dump(input logic [AW-1:0] first, input logic [AW-1:0] last);
        @(posedge CLK); #1;
        FIRST = first;
        LAST  = last;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic drain(input bit rnd, input int budget, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < budget) begin
            OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_en     = (cycles == wr_c0) || (cycles == wr_c1);
            wr_addr   = (cycles == wr_c0) ? wr_a0 : wr_a1;
            wr_data   = C_POISON;
            @(posedge CLK); #1;
            cycles++;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        preload = 1'b1;
        RST     = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < DEPTH; i++) model[i] = DW'(i) * 32'h11111111;
        n_checks++;
        if ({OUT_VALID, BUSY, DONE, OUT_ADDR, OUT_DATA, RF_ADDR} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b busy=%b done=%b addr=%0d data=%h rf_addr=%0d, required all 0",
                     OUT_VALID, BUSY, DONE, OUT_ADDR, OUT_DATA, RF_ADDR);
        end
        RST     = 1'b0;
        preload = 1'b0;
    endtask

    task automatic test_full();
        int cyc;
        push_range(5'd0, 5'd31);
        start_dump(5'd0, 5'd31);
        drain(1'b0, 100, cyc);
        n_checks++;
        if (cyc != 33) begin
            n_fail++;
            $display("FAIL full_cycles: got %0d, required 33", cyc);
        end
        n_checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done: got done=%b busy=%b valid=%b, required 1 0 0", DONE, BUSY, OUT_VALID);
        end
        @(posedge CLK); #1;
        n_checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done_pulse: got done=%b busy=%b, required 0 0", DONE, BUSY);
        end
    endtask

    task automatic test_range(input logic [AW-1:0] first, input logic [AW-1:0] last, input int n);
        int cyc;
        push_range(first, last);
        start_dump(first, last);
        drain(1'b0, 100, cyc);
        n_checks++;
        if (cyc != n + 1) begin
            n_fail++;
            $display("FAIL range_%0d_%0d_cycles: got %0d, required %0d", first, last, cyc, n + 1);
        end
        n_checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL range_%0d_%0d_done: got done=%b busy=%b, required 1 0", first, last, DONE, BUSY);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_backpressure();
        int cyc;
        push_range(5'd0, 5'd31);
        start_dump(5'd0, 5'd31);
        drain(1'b1, 600, cyc);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_timeout: got %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: got %b, required 1", DONE);
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_abort();
        int  cyc;
        bit  saw_done;
        push_range(5'd0, 5'd31);
        start_dump(5'd0, 5'd31);
        OUT_READY = 1'b1;
        cyc = 0;
        while (exp_q.size() > 27 && cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
        end
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        exp_q.delete();
        n_checks++;
        if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: got valid=%b busy=%b done=%b, required 0 0 0", OUT_VALID, BUSY, DONE);
        end
        saw_done = 1'b0;
        repeat (5) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1 || OUT_VALID === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL abort_quiet: got done/valid activity=1, required 0");
        end
        test_range(5'd10, 5'd12, 3);
    endtask

    task automatic test_write();
        int cyc;
        push_range(5'd0, 5'd31);
        exp_q[20] = {5'd20, C_POISON};
        wr_c0 = 3; wr_a0 = 5'd3;
        wr_c1 = 4; wr_a1 = 5'd20;
        start_dump(5'd0, 5'd31);
        drain(1'b0, 100, cyc);
        wr_c0 = -1; wr_c1 = -1;
        model[3]  = C_POISON;
        model[20] = C_POISON;
        n_checks++;
        if (cyc != 33 || DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL write_run: got cycles=%0d done=%b, required 33 1", cyc, DONE);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_rst_mid();
        push_range(5'd0, 5'd31);
        start_dump(5'd0, 5'd31);
        OUT_READY = 1'b1;
        repeat (6) begin
            @(posedge CLK); #1;
        end
        mon_en    = 1'b0;
        OUT_READY = 1'b0;
        RST       = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if ({OUT_VALID, BUSY, DONE, OUT_ADDR, OUT_DATA, RF_ADDR} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: got valid=%b busy=%b done=%b addr=%0d data=%h rf_addr=%0d, required all 0",
                     OUT_VALID, BUSY, DONE, OUT_ADDR, OUT_DATA, RF_ADDR);
        end
        RST = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        mon_en = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full();
        test_range(5'd30, 5'd1, 4);
        test_range(5'd7, 5'd7, 1);
        test_backpressure();
        test_abort();
        test_write();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
